// File: rtl/byte_serial_adder_if.sv
// Request/response and external 8-bit adder signals of byte_serial_adder.
// slave is the controller's view; master is the surrounding environment.
interface byte_serial_adder_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic [7:0]   add_a;
  logic [7:0]   add_b;
  logic         add_cin;
  logic [7:0]   add_sum;
  logic         add_cout;

  modport slave (
    input  start, op_a, op_b, cin, add_sum, add_cout,
    output busy, done, result, carry_out, add_a, add_b, add_cin
  );

  modport master (
    output start, op_a, op_b, cin, add_sum, add_cout,
    input  busy, done, result, carry_out, add_a, add_b, add_cin
  );
endinterface

// File: rtl/byte_serial_adder.sv
// Multi-byte adder that walks one byte per clock through a single external
// 8-bit ripple adder, chaining the carry through a register between bytes.
module byte_serial_adder #(
  parameter int NBYTES = 4
) (
  input  logic               clk,
  input  logic               rst,
  byte_serial_adder_if.slave bus
);
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [NBYTES-1:0][7:0]  r_op_a;
  logic [NBYTES-1:0][7:0]  r_op_b;
  logic [NBYTES-1:0][7:0]  r_work;
  logic [NBYTES-1:0][7:0]  r_result;
  logic [NBYTES-1:0][7:0]  w_final;
  logic [IDXW-1:0]         r_idx;
  logic                    r_carry;
  logic                    r_carry_out;
  logic                    w_accept;
  logic                    w_run;
  logic                    w_last;

  assign w_run  = (r_state == S_RUN);
  assign w_last = w_run && (r_idx == LAST_IDX);

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next   = S_RUN;
          w_accept = 1'b1;
        end
      end
      S_RUN: begin
        if (r_idx == LAST_IDX) w_next = S_DONE;
      end
      S_DONE: begin
        if (bus.start) begin
          w_next   = S_RUN;
          w_accept = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Top byte comes straight from the adder so completion needs no extra cycle.
  always_comb begin
    w_final             = r_work;
    w_final[NBYTES-1]   = bus.add_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_work      <= '0;
      r_result    <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_carry_out <= 1'b0;
    end else if (w_accept) begin
      r_op_a  <= bus.op_a;
      r_op_b  <= bus.op_b;
      r_carry <= bus.cin;
      r_idx   <= '0;
      r_work  <= '0;
    end else if (w_run) begin
      r_work[r_idx] <= bus.add_sum;
      r_carry       <= bus.add_cout;
      r_idx         <= w_last ? '0 : r_idx + IDXW'(1);
      if (w_last) begin
        r_result    <= w_final;
        r_carry_out <= bus.add_cout;
      end
    end
  end

  assign bus.add_a     = w_run ? r_op_a[r_idx] : 8'h00;
  assign bus.add_b     = w_run ? r_op_b[r_idx] : 8'h00;
  assign bus.add_cin   = w_run & r_carry;
  assign bus.busy      = w_run;
  assign bus.done      = (r_state == S_DONE);
  assign bus.result    = r_result;
  assign bus.carry_out = r_carry_out;
endmodule

// File: tb/tb_byte_serial_adder.sv
// Bench for byte_serial_adder: models the external 8-bit adder, tracks the
// expected sum and cycle timing arithmetically, and checks directed cases.
module tb_byte_serial_adder;
  localparam int N = 4;
  localparam int W = 8 * N;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  byte_serial_adder_if #(.NBYTES(N)) bus ();

  byte_serial_adder #(.NBYTES(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // External combinational 8-bit adder.
  assign {bus.add_cout, bus.add_sum} = 9'(bus.add_a) + 9'(bus.add_b) + 9'(bus.add_cin);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: operation accepted at cycle acc; p = edges since acceptance.
  int          cyc = 0;
  int          acc = -100;
  int          p_prev;
  bit          m_act = 1'b0;
  logic [63:0] m_a = '0;
  logic [63:0] m_b = '0;
  logic        m_c = 1'b0;
  logic [63:0] m_sum;
  logic [63:0] e_res = '0;
  logic        e_co = 1'b0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_act = 1'b0;
      e_res = '0;
      e_co  = 1'b0;
      m_a   = '0;
      m_b   = '0;
      m_c   = 1'b0;
    end else begin
      p_prev = cyc - acc;
      cyc++;
      if (bus.start && !(m_act && p_prev <= N - 1)) begin
        acc   = cyc;
        m_act = 1'b1;
        m_a   = 64'(bus.op_a);
        m_b   = 64'(bus.op_b);
        m_c   = bus.cin;
      end else if (m_act) begin
        if (cyc - acc == N) begin
          m_sum = m_a + m_b + 64'(m_c);
          e_res = {32'd0, m_sum[31:0]};
          e_co  = m_sum[32];
        end else if (cyc - acc > N) begin
          m_act = 1'b0;
        end
      end
    end
  end

  int          cp;
  logic        x_busy;
  logic        x_done;
  logic [63:0] x_mask;
  logic [63:0] x_a;
  logic [63:0] x_b;
  logic [63:0] x_cin;

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      cp     = cyc - acc;
      x_busy = m_act && (cp <= N - 1);
      x_done = m_act && (cp == N);
      x_a    = '0;
      x_b    = '0;
      x_cin  = '0;
      if (x_busy) begin
        x_mask = (64'd1 << (8 * cp)) - 64'd1;
        x_a    = (m_a >> (8 * cp)) & 64'hFF;
        x_b    = (m_b >> (8 * cp)) & 64'hFF;
        x_cin  = ((m_a & x_mask) + (m_b & x_mask) + 64'(m_c)) >> (8 * cp);
      end
      chk("cyc_busy", 64'(bus.busy), 64'(x_busy));
      chk("cyc_done", 64'(bus.done), 64'(x_done));
      chk("cyc_result", 64'(bus.result), e_res);
      chk("cyc_carry_out", 64'(bus.carry_out), 64'(e_co));
      chk("cyc_add_a", 64'(bus.add_a), x_a);
      chk("cyc_add_b", 64'(bus.add_b), x_b);
      chk("cyc_add_cin", 64'(bus.add_cin), x_cin);
    end
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    @(posedge clk);
    #2;
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = c;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    for (n = 1; n <= 40; n++) begin
      @(posedge clk);
      #2;
      if (bus.done === 1'b1) break;
    end
    if (bus.done !== 1'b1) chk("done_timeout", 64'd0, 64'd1);
  endtask

  int n;

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    bus.cin   = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_carry_out", 64'(bus.carry_out), 64'd0);
    chk("rst_add_a", 64'(bus.add_a), 64'd0);
    chk("rst_add_cin", 64'(bus.add_cin), 64'd0);

    start_op(32'h00000001, 32'h00000001, 1'b0);
    chk("basic_add_a", 64'(bus.add_a), 64'h01);
    chk("basic_add_cin", 64'(bus.add_cin), 64'd0);
    wait_done(n);
    chk("basic_done_edge", 64'(n + 1), 64'd5);
    chk("basic_result", 64'(bus.result), 64'h00000002);
    chk("basic_carry_out", 64'(bus.carry_out), 64'd0);

    start_op(32'hFFFFFFFF, 32'h00000001, 1'b0);
    chk("ripple_cin_c1", 64'(bus.add_cin), 64'd0);
    for (int k = 2; k <= 4; k++) begin
      @(posedge clk);
      #2;
      chk("ripple_cin_c2to4", 64'(bus.add_cin), 64'd1);
    end
    wait_done(n);
    chk("ripple_result", 64'(bus.result), 64'h00000000);
    chk("ripple_carry_out", 64'(bus.carry_out), 64'd1);

    start_op(32'hFFFFFFFF, 32'h00000000, 1'b1);
    wait_done(n);
    chk("initc_result", 64'(bus.result), 64'h00000000);
    chk("initc_carry_out", 64'(bus.carry_out), 64'd1);

    start_op(32'h00198101, 32'h00318101, 1'b0);
    wait_done(n);
    chk("mixed_result", 64'(bus.result), 64'h004B0202);
    chk("mixed_carry_out", 64'(bus.carry_out), 64'd0);

    start_op(32'h01010101, 32'h02020202, 1'b0);
    @(posedge clk);
    #2;
    bus.start = 1'b1;
    bus.op_a  = 32'h12345678;
    bus.op_b  = 32'h00000001;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    wait_done(n);
    chk("busystart_result", 64'(bus.result), 64'h03030303);
    bus.start = 1'b1;
    bus.op_a  = 32'h80000000;
    bus.op_b  = 32'h80000000;
    bus.cin   = 1'b0;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    chk("b2b_busy", 64'(bus.busy), 64'd1);
    chk("b2b_done", 64'(bus.done), 64'd0);
    wait_done(n);
    chk("b2b_result", 64'(bus.result), 64'h00000000);
    chk("b2b_carry_out", 64'(bus.carry_out), 64'd1);

    start_op(32'h11111111, 32'h22222222, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_result", 64'(bus.result), 64'd0);
    chk("abort_carry_out", 64'(bus.carry_out), 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #2;
      chk("abort_no_done", 64'(bus.done), 64'd0);
    end
    start_op(32'h000000FF, 32'h00000001, 1'b0);
    wait_done(n);
    chk("fresh_result", 64'(bus.result), 64'h00000100);
    chk("fresh_carry_out", 64'(bus.carry_out), 64'd0);

    repeat (2) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
